// File: rtl/q_logger_pkg.sv
// Shared types for the Q change logger: FSM states, event layout and
// the saturating counter helper used by the optional statistics.
package q_logger_pkg;

    localparam int Q_W      = 3;
    localparam int TS_W_DEF = 12;
    localparam int CNT_W    = 16;

    typedef enum logic {
        UNPRIMED,
        ARMED
    } q_log_state_t;

    typedef struct packed {
        logic [Q_W-1:0]      q;
        logic [TS_W_DEF-1:0] ts;
    } q_event_t;

    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] v
    );
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/q_event_fifo.sv
// Generic DEPTH-entry synchronous FIFO; head is read straight from
// registered storage so it never bypasses a same-cycle write.
module q_event_fifo #(
    parameter  int W     = 15,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty;
    // A push into a full FIFO only lands when the head leaves this cycle.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wptr] <= din;
                wptr      <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/q_change_logger.sv
// Logs every change of the upstream Q value with a timestamp into a FIFO.
// Define Q_CHANGE_LOGGER_STATS_EN to add the saturating change_count port.
module q_change_logger
    import q_logger_pkg::*;
#(
    parameter  int TS_W  = 12,
    parameter  int DEPTH = 4,
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [Q_W-1:0]  q_in,
    input  logic            q_en,
    output logic            ev_valid,
    input  logic            ev_ready,
    output logic [Q_W-1:0]  ev_q,
    output logic [TS_W-1:0] ev_ts,
    output logic [LW-1:0]   level,
    output logic            overflow,
    input  logic            clr_ovf
`ifdef Q_CHANGE_LOGGER_STATS_EN
    ,
    output logic [CNT_W-1:0] change_count
`endif
);

    typedef struct packed {
        logic [Q_W-1:0]  q;
        logic [TS_W-1:0] ts;
    } ev_t;

    localparam int EW = $bits(ev_t);

    q_log_state_t    state;
    q_log_state_t    state_nxt;
    logic [Q_W-1:0]  last_q;
    logic [TS_W-1:0] ts;
    logic            ev_fire;
    logic            pop;
    logic            full;
    logic            empty;
    logic            drop;
    ev_t             wr_ev;
    ev_t             rd_ev;

    always_comb begin
        state_nxt = state;
        ev_fire   = 1'b0;
        unique case (1'b1)
            (state == UNPRIMED): begin
                if (q_en) begin
                    state_nxt = ARMED;
                end
            end
            (state == ARMED): begin
                ev_fire = q_en && (q_in != last_q);
            end
            default: state_nxt = UNPRIMED;
        endcase
    end

    assign ev_valid = !empty;
    assign pop      = ev_valid && ev_ready;
    assign drop     = ev_fire && full && !pop;
    assign wr_ev    = '{q: q_in, ts: ts};
    assign ev_q     = rd_ev.q;
    assign ev_ts    = rd_ev.ts;

    q_event_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (ev_fire),
        .pop   (pop),
        .din   (wr_ev),
        .dout  (rd_ev),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= UNPRIMED;
            last_q   <= '0;
            ts       <= '0;
            overflow <= 1'b0;
        end else begin
            state <= state_nxt;
            ts    <= ts + 1'b1;
            if (q_en) begin
                last_q <= q_in;
            end
            // A drop in the same cycle as a clear keeps the flag set.
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

`ifdef Q_CHANGE_LOGGER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            change_count <= '0;
        end else if (ev_fire) begin
            change_count <= sat_inc(change_count);
        end
    end
`endif

endmodule
